// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types and the L1 pmem arbiter state encoding.
`default_nettype none

package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] cache_line;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  // Encoding of the last-served side for the round-robin variant.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/l1_pmem_arbiter_req_reg.sv
// arb_req_reg: load/clear register bundle holding the granted downstream request.
`default_nettype none

module arb_req_reg
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              read_in,
  input  logic              write_in,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [LINE_W-1:0] wdata_in,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [LINE_W-1:0] wdata
);

  // Clear only drops the strobes; address/wdata simply go stale until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      read    <= 1'b0;
      write   <= 1'b0;
      address <= '0;
      wdata   <= '0;
    end else if (load) begin
      read    <= read_in;
      write   <= write_in;
      address <= address_in;
      wdata   <= wdata_in;
    end else if (clear) begin
      read    <= 1'b0;
      write   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/l1_pmem_arbiter.sv
// l1_pmem_arbiter: shares one line-granular memory port between L1 I- and D-cache.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention; default is D over I.
`default_nettype none

module l1_pmem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state;
  logic              d_req;
  logic              grant_d;
  logic              grant_i;
  logic              load;
  logic              clear;
  logic              ld_read;
  logic              ld_write;
  logic [ADDR_W-1:0] ld_address;
  logic [LINE_W-1:0] ld_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;
`endif

  // Grants are only ever issued from IDLE, which enforces the one-cycle turnaround.
  always_comb begin
    d_req   = d_pmem_read | d_pmem_write;
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_d = d_req & (~i_pmem_read | (last_grant == GRANT_I));
`else
      grant_d = d_req;
`endif
      grant_i = i_pmem_read & ~grant_d;
    end
  end

  always_comb begin
    load       = grant_d | grant_i;
    clear      = (state != IDLE) & mem_resp;
    ld_read    = grant_d ? (d_pmem_read & ~d_pmem_write) : 1'b1;
    ld_write   = grant_d & d_pmem_write;
    ld_address = grant_d ? d_pmem_address : i_pmem_address;
    ld_wdata   = grant_d ? d_pmem_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= GRANT_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state <= D_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= GRANT_D;
`endif
          end else if (grant_i) begin
            state <= I_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= GRANT_I;
`endif
          end
        end
        I_BUSY, D_BUSY: begin
          if (mem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  arb_req_reg #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) u_req_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .clear     (clear),
    .read_in   (ld_read),
    .write_in  (ld_write),
    .address_in(ld_address),
    .wdata_in  (ld_wdata),
    .read      (mem_read),
    .write     (mem_write),
    .address   (mem_address),
    .wdata     (mem_wdata)
  );

  // Both caches see the raw line; only the granted side's resp qualifies it.
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign i_pmem_resp  = (state == I_BUSY) & mem_resp;
  assign d_pmem_resp  = (state == D_BUSY) & mem_resp;

endmodule

`default_nettype wire

// File: tb/tb_l1_pmem_arbiter.sv
// Scoreboard bench for l1_pmem_arbiter: a small downstream memory model serves queued requests.
`default_nettype none

module tb_l1_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;

  always #5 clk = ~clk;

  l1_pmem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {
    bit           is_d;
    bit           rd;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   last_d   = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic exp_t mk(input bit is_d, input bit rd, input bit wr,
                              input logic [15:0] addr, input logic [127:0] wdata,
                              input logic [127:0] rdata);
    exp_t e;
    e.is_d = is_d; e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    return e;
  endfunction

  // Wait for the next downstream request, hold it for lat cycles, then respond.
  task automatic serve(input int lat, input bit rel);
    exp_t e;
    bit   got;
    int   waited;
    got = 1'b0;
    waited = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk); #1;
      waited++;
      if (mem_read | mem_write) got = 1'b1;
    end
    if (!got) begin
      check("req_timeout", 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    last_d = e.is_d;
    check("grant_latency", waited, 1);
    check("mem_read", mem_read, e.rd);
    check("mem_write", mem_write, e.wr);
    check("mem_address", mem_address, e.addr);
    if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
    for (int k = 1; k < lat; k++) begin
      if (e.is_d) begin
        d_pmem_wdata   = ~d_pmem_wdata;
        d_pmem_address = d_pmem_address ^ 16'hffff;
      end else begin
        i_pmem_address = i_pmem_address ^ 16'hffff;
      end
      @(negedge clk); #1;
      check("hold_rw", {mem_read, mem_write}, {e.rd, e.wr});
      check("hold_address", mem_address, e.addr);
      if (e.wr) check("hold_wdata", mem_wdata, e.wdata);
    end
    mem_resp  = 1'b1;
    mem_rdata = e.rdata;
    #1;
    check("i_resp", i_pmem_resp, !e.is_d);
    check("d_resp", d_pmem_resp, e.is_d);
    if (e.is_d) check("d_rdata", d_pmem_rdata, e.rdata);
    else        check("i_rdata", i_pmem_rdata, e.rdata);
    @(negedge clk);
    mem_resp = 1'b0;
    if (rel) begin
      if (e.is_d) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
      else i_pmem_read = 1'b0;
    end
    #1;
    check("gap_rw", {mem_read, mem_write}, 2'b00);
    check("gap_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
  endtask

  task automatic contend();
    bit d_first;
`ifdef ARB_ROUND_ROBIN_EN
    d_first = !last_d;
`else
    d_first = 1'b1;
`endif
    i_pmem_read = 1'b1; i_pmem_address = 16'h1000;
    d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
    if (d_first) begin
      sb.push_back(mk(1, 1, 0, 16'h2000, '0, {4{32'h2222_0000}}));
      sb.push_back(mk(0, 1, 0, 16'h1000, '0, {4{32'h1111_0000}}));
    end else begin
      sb.push_back(mk(0, 1, 0, 16'h1000, '0, {4{32'h1111_0000}}));
      sb.push_back(mk(1, 1, 0, 16'h2000, '0, {4{32'h2222_0000}}));
    end
    serve(2, 1);
    serve(2, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_rw", {mem_read, mem_write}, 2'b00);
    check("rst_mem_addr", mem_address, 16'h0);
    check("rst_mem_wdata", mem_wdata, '0);
    rst = 1'b0;

    // Stale mem_resp while idle must not reach either cache.
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = {4{32'hDEAD_BEEF}};
    #1;
    check("idle_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    check("idle_rw", {mem_read, mem_write}, 2'b00);

    // Lone I read.
    i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
    sb.push_back(mk(0, 1, 0, 16'h1230, '0, {16{8'hA5}}));
    #1;
    check("no_same_cycle_grant", mem_read, 1'b0);
    serve(3, 1);

    // D writeback with wdata changed mid-transaction.
    d_pmem_write = 1'b1; d_pmem_address = 16'h4560;
    d_pmem_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    sb.push_back(mk(1, 0, 1, 16'h4560, 128'h0123456789ABCDEF0123456789ABCDEF, '0));
    serve(3, 1);

    // Two rounds of simultaneous I/D requests.
    contend();
    contend();

    // D read held through its resp cycle: no re-grant until IDLE, then granted again.
    d_pmem_read = 1'b1; d_pmem_address = 16'h3000;
    sb.push_back(mk(1, 1, 0, 16'h3000, '0, {4{32'h3333_3333}}));
    sb.push_back(mk(1, 1, 0, 16'h3000, '0, {4{32'h4444_4444}}));
    serve(1, 0);
    serve(1, 1);

    // Reset in D_BUSY abandons the transaction.
    d_pmem_write = 1'b1; d_pmem_address = 16'h5550; d_pmem_wdata = {4{32'h5555_AAAA}};
    @(negedge clk); #1;
    check("pre_rst_write", mem_write, 1'b1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_rw", {mem_read, mem_write}, 2'b00);
    rst = 1'b0; d_pmem_write = 1'b0; last_d = 1'b0;
    mem_resp = 1'b1;
    #1;
    check("post_rst_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    check("post_rst_rw", {mem_read, mem_write}, 2'b00);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
